// File: rtl/mpu_pkg.sv
// -----------------------------------------------------------------------------
// mpu_pkg
// Shared types for the programmable MPU control stage: instruction opcode and
// register-code enums, ALU operation codes, the datapath control bundle and
// small helpers that slice the fixed 8-bit instruction format.
//
// Instruction format (8 bits):
//   [7:5] op   [4:3] dst   [2] unused   [1:0] src
//   JMP uses the low AW bits as the absolute target address.
// -----------------------------------------------------------------------------
package mpu_pkg;

  // Instruction width; the encoding below only fits 8 bits.
  localparam int IW = 8;

  // Default program depth.
  localparam int DEPTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_MOV  = 3'b001,
    OP_MOVM = 3'b010,
    OP_ADC  = 3'b011,
    OP_SBC  = 3'b100,
    OP_CLR  = 3'b101,
    OP_JMP  = 3'b110,
    OP_HALT = 3'b111
  } op_e;

  // Register codes shared by the dst/src fields, ce_o bit positions and the
  // ALU B-select.
  typedef enum logic [1:0] {
    REG_R0 = 2'b00,
    REG_R1 = 2'b01,
    REG_R2 = 2'b10,
    REG_A  = 2'b11
  } reg_e;

  typedef enum logic [2:0] {
    ALU_PASS_B = 3'b000,
    ALU_ADC    = 3'b001,
    ALU_SBC    = 3'b010
  } alu_op_e;

  // Control bundle driven into the datapath for one EXEC cycle.
  typedef struct packed {
    logic       clr;   // synchronous datapath clear
    logic [3:0] ce;    // [0..2] = R0..R2, [3] = A
    logic [2:0] w;     // per-R source: 1 = M[i], 0 = ALU result
    logic [1:0] sel;   // ALU B operand select (reg_e code)
    alu_op_e    s;     // ALU operation
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{
    clr: 1'b0,
    ce:  4'b0000,
    w:   3'b000,
    sel: 2'b00,
    s:   ALU_PASS_B
  };

  // FSM states of the sequencer.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FETCH  = 2'b01,
    ST_EXEC   = 2'b10,
    ST_HALTED = 2'b11
  } state_e;

  function automatic op_e instr_op(input logic [IW-1:0] instr);
    return op_e'(instr[7:5]);
  endfunction

  function automatic reg_e instr_dst(input logic [IW-1:0] instr);
    return reg_e'(instr[4:3]);
  endfunction

  function automatic reg_e instr_src(input logic [IW-1:0] instr);
    return reg_e'(instr[1:0]);
  endfunction

endpackage

// File: rtl/mpu_decoder.sv
// -----------------------------------------------------------------------------
// mpu_decoder
// Purely combinational decode of one instruction word into the datapath
// control bundle. Only meaningful while the sequencer is in EXEC; the
// sequencer masks the result in every other state.
//
// Ports
//   i_instr  in   IW      instruction word held in the sequencer's IR
//   o_ctrl   out  ctrl_t  decoded clr/ce/w/sel/s
// -----------------------------------------------------------------------------
module mpu_decoder
  import mpu_pkg::*;
(
  input  logic [IW-1:0] i_instr,
  output ctrl_t         o_ctrl
);

  op_e  w_op;
  reg_e w_dst;
  reg_e w_src;

  // Bit 2 carries no meaning in any opcode; the JMP target bits are consumed
  // by the sequencer's PC logic instead of here.
  logic w_unused;

  assign w_op     = instr_op(i_instr);
  assign w_dst    = instr_dst(i_instr);
  assign w_src    = instr_src(i_instr);
  assign w_unused = i_instr[2];

  always_comb begin
    // NOTE: the whole bundle gets a default before the case so every path
    // assigns every field and no latch is inferred.
    o_ctrl = CTRL_NONE;
    case (w_op)
      OP_MOV: begin
        // MOV A,A is legal: ce[3] with sel=A simply reloads A through PASS_B.
        o_ctrl.ce[w_dst] = 1'b1;
        o_ctrl.sel       = w_src;
        o_ctrl.s         = ALU_PASS_B;
      end
      OP_MOVM: begin
        o_ctrl.ce = 4'b0111;
        o_ctrl.w  = 3'b111;
      end
      OP_ADC: begin
        // Accumulator op: the dst field is ignored, result always goes to A.
        o_ctrl.ce  = 4'b1000;
        o_ctrl.sel = w_src;
        o_ctrl.s   = ALU_ADC;
      end
      OP_SBC: begin
        o_ctrl.ce  = 4'b1000;
        o_ctrl.sel = w_src;
        o_ctrl.s   = ALU_SBC;
      end
      OP_CLR: begin
        o_ctrl.clr = 1'b1;
      end
      default: begin
        // NOP, JMP and HALT touch no datapath enables.
        o_ctrl = CTRL_NONE;
      end
    endcase
  end

endmodule

// File: rtl/mpu_sequencer.sv
// -----------------------------------------------------------------------------
// mpu_sequencer
// Programmable control stage for the 4-bit MPU datapath. Holds a DEPTH-word
// instruction RAM and runs a two-cycle FETCH/EXEC loop, driving the datapath
// control bus for exactly one cycle per instruction.
//
// Ports
//   clk          in   1    rising-edge clock
//   reset        in   1    asynchronous, active-high reset
//   start_i      in   1    run from address 0 (accepted in IDLE/HALTED only)
//   prog_we_i    in   1    program write strobe (accepted in IDLE/HALTED only)
//   prog_addr_i  in   AW   program write address
//   prog_data_i  in   IW   program write data
//   busy_o       out  1    high in FETCH/EXEC
//   done_o       out  1    one-cycle pulse on entry to HALTED
//   pc_o         out  AW   current program counter
//   clr_o        out  1    datapath synchronous clear
//   ce_o         out  4    register enables [0..2]=R0..R2, [3]=A
//   w_o          out  3    per-R mux: 1 = M[i], 0 = ALU result
//   sel_o        out  2    ALU B select
//   s_o          out  3    ALU op
// -----------------------------------------------------------------------------
module mpu_sequencer
  import mpu_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic          prog_we_i,
  input  logic [AW-1:0] prog_addr_i,
  input  logic [IW-1:0] prog_data_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] pc_o,
  output logic          clr_o,
  output logic [3:0]    ce_o,
  output logic [2:0]    w_o,
  output logic [1:0]    sel_o,
  output logic [2:0]    s_o
);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_e        r_state;
  state_e        w_next_state;

  logic [IW-1:0] r_mem [DEPTH];
  logic [IW-1:0] r_instr;       // IR: word fetched in FETCH, decoded in EXEC
  logic [AW-1:0] r_pc;
  logic          r_first;       // first FETCH after an accepted start
  logic          r_done;

  logic          w_host_ok;     // host handshake only honoured when stopped
  logic          w_start;
  logic          w_write;
  op_e           w_op;
  logic          w_exec_halt;
  logic [AW-1:0] w_pc_inc;
  ctrl_t         w_ctrl;

  assign w_host_ok   = (r_state == ST_IDLE) || (r_state == ST_HALTED);
  assign w_start     = start_i   && w_host_ok;
  assign w_write     = prog_we_i && w_host_ok;
  assign w_op        = instr_op(r_instr);
  assign w_exec_halt = (r_state == ST_EXEC) && (w_op == OP_HALT);

  // Explicit wrap keeps non-power-of-two depths correct.
  assign w_pc_inc = (r_pc == AW'(DEPTH - 1)) ? '0 : r_pc + AW'(1);

  // ---------------------------------------------------------------------------
  // Decoder
  // ---------------------------------------------------------------------------
  mpu_decoder u_decoder (
    .i_instr (r_instr),
    .o_ctrl  (w_ctrl)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE,
      ST_HALTED: if (w_start) w_next_state = ST_FETCH;
      ST_FETCH:  w_next_state = ST_EXEC;
      ST_EXEC:   w_next_state = w_exec_halt ? ST_HALTED : ST_FETCH;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // Controls are a function of state only, so an async reset forces them to
  // zero in the same cycle, even mid-EXEC.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o = 1'b0;
    done_o = r_done;
    pc_o   = r_pc;
    clr_o  = 1'b0;
    ce_o   = 4'b0000;
    w_o    = 3'b000;
    sel_o  = 2'b00;
    s_o    = 3'b000;
    case (r_state)
      ST_FETCH: begin
        busy_o = 1'b1;
        // Clean datapath at the start of every run.
        clr_o  = r_first;
      end
      ST_EXEC: begin
        busy_o = 1'b1;
        clr_o  = w_ctrl.clr;
        ce_o   = w_ctrl.ce;
        w_o    = w_ctrl.w;
        sel_o  = w_ctrl.sel;
        s_o    = w_ctrl.s;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Program RAM
  // ---------------------------------------------------------------------------
  // NOTE: the RAM has no reset on purpose: the program must survive a reset,
  // and leaving it out keeps it mappable onto a plain RAM macro.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[prog_addr_i] <= prog_data_i;
    end
  end

  // Synchronous read into the IR. A write committed together with start is
  // already in the array by the first FETCH edge, so that fetch sees it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= '0;
    end else if (r_state == ST_FETCH) begin
      r_instr <= r_mem[r_pc];
    end
  end

  // ---------------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= '0;
    end else if (w_start) begin
      r_pc <= '0;
    end else if (r_state == ST_EXEC) begin
      case (w_op)
        OP_JMP:  r_pc <= r_instr[AW-1:0];
        OP_HALT: r_pc <= r_pc;
        default: r_pc <= w_pc_inc;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Run bookkeeping: first-FETCH flag and done pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_first <= 1'b0;
    end else if (w_start) begin
      r_first <= 1'b1;
    end else if (r_state == ST_FETCH) begin
      r_first <= 1'b0;
    end
  end

  // Set only by the HALT EXEC, so it lasts exactly the first HALTED cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_exec_halt;
    end
  end

endmodule

// File: tb/tb_mpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mpu_sequencer
// Directed bench for mpu_sequencer. A program-level model interprets the
// bench's own copy of the program and produces the per-cycle output trace a
// run must show; a compare process checks every cycle against it. A small
// behavioural datapath driven by the DUT controls pins arithmetic results.
// -----------------------------------------------------------------------------
module tb_mpu_sequencer;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_i;
  logic       prog_we_i;
  logic [4:0] prog_addr_i;
  logic [7:0] prog_data_i;
  logic       busy_o;
  logic       done_o;
  logic [4:0] pc_o;
  logic       clr_o;
  logic [3:0] ce_o;
  logic [2:0] w_o;
  logic [1:0] sel_o;
  logic [2:0] s_o;

  mpu_sequencer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .prog_we_i   (prog_we_i),
    .prog_addr_i (prog_addr_i),
    .prog_data_i (prog_data_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pc_o        (pc_o),
    .clr_o       (clr_o),
    .ce_o        (ce_o),
    .w_o         (w_o),
    .sel_o       (sel_o),
    .s_o         (s_o)
  );

  always #5 clk = ~clk;

  // Instruction encodings used below.
  localparam logic [7:0] I_NOP    = 8'h00;
  localparam logic [7:0] I_MOVM   = 8'h40;
  localparam logic [7:0] I_MOV_A0 = 8'h38;  // MOV A,R0
  localparam logic [7:0] I_ADC_R1 = 8'h61;
  localparam logic [7:0] I_SBC_R1 = 8'h81;
  localparam logic [7:0] I_HALT   = 8'hE0;
  localparam logic [7:0] I_JMP0   = 8'hC0;
  localparam logic [7:0] I_JMP31  = 8'hDF;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [4:0] pc;
    logic       clr;
    logic [3:0] ce;
    logic [2:0] w;
    logic [1:0] sel;
    logic [2:0] s;
  } obs_t;

  obs_t w_obs;
  assign w_obs = {busy_o, done_o, pc_o, clr_o, ce_o, w_o, sel_o, s_o};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Program-level model
  // ---------------------------------------------------------------------------
  logic [7:0] prog_m [DEPTH];
  obs_t       exp_q [$];
  obs_t       idle_e = '0;

  // What the control bus must show while instruction `ins` executes.
  function automatic obs_t exec_obs(input logic [7:0] ins, input int pc);
    obs_t e;
    e      = '0;
    e.busy = 1'b1;
    e.pc   = 5'(pc);
    case (ins[7:5])
      3'd1: begin e.ce[ins[4:3]] = 1'b1; e.sel = ins[1:0]; end
      3'd2: begin e.ce = 4'b0111; e.w = 3'b111; end
      3'd3: begin e.ce = 4'b1000; e.sel = ins[1:0]; e.s = 3'd1; end
      3'd4: begin e.ce = 4'b1000; e.sel = ins[1:0]; e.s = 3'd2; end
      3'd5: e.clr = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  // Interpret the program from address 0 for up to max_instr instructions,
  // two cycles each, and queue the expected observation per cycle.
  task automatic build_trace(input int max_instr);
    int   pc;
    obs_t e;
    pc = 0;
    for (int n = 0; n < max_instr; n++) begin
      e      = '0;
      e.busy = 1'b1;
      e.pc   = 5'(pc);
      e.clr  = (n == 0);
      exp_q.push_back(e);
      exp_q.push_back(exec_obs(prog_m[pc], pc));
      if (prog_m[pc][7:5] == 3'd7) begin
        e      = '0;
        e.done = 1'b1;
        e.pc   = 5'(pc);
        exp_q.push_back(e);
        e.done = 1'b0;
        idle_e = e;
        return;
      end else if (prog_m[pc][7:5] == 3'd6) begin
        pc = int'(prog_m[pc][4:0]);
      end else begin
        pc = (pc + 1) % DEPTH;
      end
    end
  endtask

  // One compare per cycle, sampled 1 time unit after the active edge.
  initial begin
    obs_t want;
    forever begin
      @(posedge clk);
      #1;
      want = (exp_q.size() > 0) ? exp_q.pop_front() : idle_e;
      check("cycle_trace", 32'(w_obs), 32'(want));
    end
  end

  // ---------------------------------------------------------------------------
  // Behavioural datapath driven by the DUT control bus
  // ---------------------------------------------------------------------------
  logic [3:0] m_in [3];
  logic       cin;
  logic [3:0] dp_r [3];
  logic [3:0] dp_a;

  always @(posedge clk) begin : datapath
    logic [3:0] b;
    logic [3:0] alu;
    b = (sel_o == 2'd3) ? dp_a : dp_r[sel_o];
    case (s_o)
      3'd0:    alu = b;
      3'd1:    alu = dp_a + b + {3'b000, cin};
      3'd2:    alu = dp_a + ~b + {3'b000, cin};
      default: alu = 4'h0;
    endcase
    if (clr_o) begin
      for (int i = 0; i < 3; i++) dp_r[i] <= 4'h0;
      dp_a <= 4'h0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (ce_o[i]) dp_r[i] <= w_o[i] ? m_in[i] : alu;
      if (ce_o[3]) dp_a <= alu;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic write_word(input int a, input logic [7:0] d);
    prog_we_i   = 1'b1;
    prog_addr_i = 5'(a);
    prog_data_i = d;
    prog_m[a]   = d;
    @(negedge clk);
    prog_we_i   = 1'b0;
  endtask

  task automatic start_run(input int max_instr);
    start_i = 1'b1;
    build_trace(max_instr);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic apply_reset(input string name);
    reset = 1'b1;
    exp_q.delete();
    idle_e = '0;
    #1;
    check({name, "_rst_ce"},   32'(ce_o),   32'd0);
    check({name, "_rst_busy"}, 32'(busy_o), 32'd0);
    check({name, "_rst_pc"},   32'(pc_o),   32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    reset       = 1'b1;
    start_i     = 1'b0;
    prog_we_i   = 1'b0;
    prog_addr_i = '0;
    prog_data_i = '0;
    cin         = 1'b0;
    for (int i = 0; i < 3; i++) begin m_in[i] = 4'h0; dp_r[i] = 4'h0; end
    dp_a = 4'h0;
    for (int i = 0; i < DEPTH; i++) prog_m[i] = I_NOP;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_pc",   32'(pc_o),   32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: MOVM; HALT
    write_word(0, I_MOVM);
    write_word(1, I_HALT);
    start_run(4);
    check("t1_first_fetch_clr", 32'(clr_o), 32'd1);
    @(negedge clk);
    check("t1_exec_ce", 32'(ce_o), 32'h7);
    check("t1_exec_w",  32'(w_o),  32'h7);
    repeat (3) @(negedge clk);
    check("t1_done",      32'(done_o), 32'd1);
    check("t1_done_busy", 32'(busy_o), 32'd0);
    check("t1_done_pc",   32'(pc_o),   32'd1);
    @(negedge clk);
    check("t1_done_once", 32'(done_o), 32'd0);
    check("t1_pc_hold",   32'(pc_o),   32'd1);

    // 2: M={3,5,0}, Cin=0: MOVM; MOV A,R0; ADC R1; HALT -> A=8
    m_in[0] = 4'd3; m_in[1] = 4'd5; m_in[2] = 4'd0; cin = 1'b0;
    write_word(1, I_MOV_A0);
    write_word(2, I_ADC_R1);
    write_word(3, I_HALT);
    start_run(8);
    wait_drain("t2");
    check("t2_acc", 32'(dp_a), 32'd8);

    // 3: M={8,5,0}, Cin=1: SBC R1 -> A=3
    m_in[0] = 4'd8; cin = 1'b1;
    write_word(2, I_SBC_R1);
    start_run(8);
    repeat (5) @(negedge clk);
    check("t3_sbc_s",   32'(s_o),   32'd2);
    check("t3_sbc_sel", 32'(sel_o), 32'd1);
    wait_drain("t3");
    check("t3_acc", 32'(dp_a), 32'd3);

    // 4a: JMP 0 at address 3 loops 0,1,2,3,0,...
    write_word(0, I_NOP);
    write_word(1, I_NOP);
    write_word(2, I_NOP);
    write_word(3, I_JMP0);
    start_run(10);
    repeat (8) @(negedge clk);
    check("t4_jmp_pc",  32'(pc_o),  32'd0);
    check("t4_jmp_clr", 32'(clr_o), 32'd0);
    wait_drain("t4a");
    apply_reset("t4a");

    // 4b: NOP at DEPTH-1 falls through to 0
    write_word(0, I_JMP31);
    write_word(31, I_NOP);
    start_run(6);
    repeat (2) @(negedge clk);
    check("t4_pc_top", 32'(pc_o), 32'd31);
    repeat (2) @(negedge clk);
    check("t4_pc_wrap", 32'(pc_o), 32'd0);
    wait_drain("t4b");
    apply_reset("t4b");

    // 5: reset during the ADC EXEC, then re-run the intact program
    m_in[0] = 4'd3; m_in[1] = 4'd5; cin = 1'b0;
    write_word(0, I_MOVM);
    write_word(1, I_MOV_A0);
    write_word(2, I_ADC_R1);
    write_word(3, I_HALT);
    start_run(8);
    n = 0;
    while (!(ce_o == 4'b1000 && s_o == 3'd1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_found_adc", 32'(n < 20), 32'd1);
    apply_reset("t5");
    start_run(8);
    wait_drain("t5");
    check("t5_acc", 32'(dp_a), 32'd8);

    // 6: program write and start while busy are ignored
    write_word(0, I_NOP);
    write_word(1, I_NOP);
    write_word(2, I_NOP);
    write_word(3, I_HALT);
    start_run(8);
    prog_we_i   = 1'b1;
    prog_addr_i = 5'd1;
    prog_data_i = I_HALT;
    start_i     = 1'b1;
    @(negedge clk);
    prog_we_i = 1'b0;
    start_i   = 1'b0;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_drain("t6a");
    repeat (2) @(negedge clk);
    start_run(8);
    wait_drain("t6b");

    // 7: write and start in the same IDLE cycle; first fetch sees new word
    apply_reset("t7");
    prog_we_i   = 1'b1;
    prog_addr_i = 5'd0;
    prog_data_i = I_HALT;
    prog_m[0]   = I_HALT;
    start_run(4);
    prog_we_i = 1'b0;
    wait_drain("t7");
    check("t7_pc", 32'(pc_o), 32'd0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
